// File: rtl/board_writer_pkg.sv
// board_writer_pkg: constants, codes and the move-FSM state type shared by
// board_writer, its read mux and the board scanners.
//   - SQ_W / NUM_SQ / BOARD_W / POS_W : square, board and position widths
//   - PIECE_* : piece type codes held in bits [2:0] of a square
//   - DIR_*   : scan direction codes used by the scanners
//   - ERR_*   : errCode values reported on a rejected move
//   - state_t : move FSM states
//   - move_check() : rejection reason for a move, in priority order
package board_writer_pkg;

  localparam int SQ_W    = 4;
  localparam int NUM_SQ  = 64;
  localparam int BOARD_W = SQ_W * NUM_SQ;
  localparam int POS_W   = 6;

  localparam logic [2:0] PIECE_EMPTY = 3'b000;
  localparam logic [2:0] PIECE_PAWN  = 3'b001;
  localparam logic [2:0] PIECE_QUEEN = 3'b101;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_SRC_EMPTY   = 2'b01;
  localparam logic [1:0] ERR_SAME_COLOUR = 2'b10;
  localparam logic [1:0] ERR_SAME_SQ     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Highest-priority reason wins: same square, then empty source, then a
  // destination occupied by a piece of the mover's own colour.
  function automatic logic [1:0] move_check(input logic [SQ_W-1:0]  src,
                                            input logic [SQ_W-1:0]  dst,
                                            input logic [POS_W-1:0] from_pos,
                                            input logic [POS_W-1:0] to_pos);
    logic [1:0] code;
    if (from_pos == to_pos) begin
      code = ERR_SAME_SQ;
    end else if (src[2:0] == PIECE_EMPTY) begin
      code = ERR_SRC_EMPTY;
    end else if ((dst[2:0] != PIECE_EMPTY) && (dst[3] == src[3])) begin
      code = ERR_SAME_COLOUR;
    end else begin
      code = ERR_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/board_writer_square_mux.sv
// square_mux: 64:1 read mux returning one 4-bit square of the packed board.
//   board : packed board, square n at bits [4n+3:4n]
//   sel   : square index (column*8 + row)
//   piece : contents of the selected square
module square_mux
  import board_writer_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [POS_W-1:0]   sel,
  output logic [SQ_W-1:0]    piece
);

  assign piece = board[int'(sel) * SQ_W +: SQ_W];

endmodule

// File: rtl/board_writer.sv
// board_writer: sole writer of the packed 64-square board. Accepts one move
// at a time over moveValid/moveReady, reads source and destination squares,
// rejects illegal moves with moveErr/errCode, otherwise lifts the source
// piece onto the destination and pulses moveDone.
// Ports:
//   clk, rst_n       : clock (rising edge), async active-low reset
//   initLoad         : one-cycle pulse, reload INIT_BOARD and abort any move
//   moveValid/Ready  : move handshake (moveReady combinational from state)
//   fromPos, toPos   : source / destination square, index = column*8 + row
//   bigBoard         : registered board
//   moveDone/moveErr : one-cycle result pulses; errCode valid with moveErr
//   capturedPiece    : previous contents of toPos for the last applied move
//   busy             : FSM not idle
//   promoted         : (BOARD_WRITER_PROMOTION_EN only) pawn became a queen
// Optional feature macro: BOARD_WRITER_PROMOTION_EN.
module board_writer
  import board_writer_pkg::*;
#(
  parameter logic [BOARD_W-1:0] INIT_BOARD = {BOARD_W{1'b0}}
`ifdef BOARD_WRITER_PROMOTION_EN
  ,
  parameter logic [2:0] QUEEN_CODE = 3'b101,
  parameter logic [2:0] PAWN_CODE  = 3'b001
`endif
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               initLoad,
  input  logic               moveValid,
  output logic               moveReady,
  input  logic [POS_W-1:0]   fromPos,
  input  logic [POS_W-1:0]   toPos,
  output logic [BOARD_W-1:0] bigBoard,
  output logic               moveDone,
  output logic               moveErr,
  output logic [1:0]         errCode,
  output logic [SQ_W-1:0]    capturedPiece,
  output logic               busy
`ifdef BOARD_WRITER_PROMOTION_EN
  ,
  output logic               promoted
`endif
);

  state_t             state_r, state_next_s;
  logic [BOARD_W-1:0] board_r, write_board_s;
  logic [POS_W-1:0]   from_r, to_r;
  logic [SQ_W-1:0]    src_r, dst_r;
  logic [SQ_W-1:0]    src_s, dst_s;
  logic [SQ_W-1:0]    new_piece_s;
  logic [1:0]         err_s;
  logic               accept_s;

  assign moveReady = (state_r == ST_IDLE) & ~initLoad;
  assign busy      = (state_r != ST_IDLE);
  assign accept_s  = moveValid & moveReady;
  assign bigBoard  = board_r;
  assign err_s     = move_check(src_r, dst_r, from_r, to_r);

  square_mux u_src_mux (.board(board_r), .sel(from_r), .piece(src_s));
  square_mux u_dst_mux (.board(board_r), .sel(to_r),   .piece(dst_s));

`ifdef BOARD_WRITER_PROMOTION_EN
  logic promote_s;

  // A pawn reaching row 0 or row 7 is written back as a queen of its colour.
  always_comb begin
    new_piece_s = src_r;
    promote_s   = 1'b0;
    if ((src_r[2:0] == PAWN_CODE) && ((to_r[2:0] == 3'd0) || (to_r[2:0] == 3'd7))) begin
      new_piece_s = {src_r[3], QUEEN_CODE};
      promote_s   = 1'b1;
    end else begin
      new_piece_s = src_r;
      promote_s   = 1'b0;
    end
  end
`else
  assign new_piece_s = src_r;
`endif

  // One-hot square-enable decode: destination takes the piece, source is cleared.
  always_comb begin
    write_board_s = board_r;
    for (int i = 0; i < NUM_SQ; i++) begin
      if (to_r == 6'(i)) begin
        write_board_s[i * SQ_W +: SQ_W] = new_piece_s;
      end else if (from_r == 6'(i)) begin
        write_board_s[i * SQ_W +: SQ_W] = 4'h0;
      end else begin
        write_board_s[i * SQ_W +: SQ_W] = board_r[i * SQ_W +: SQ_W];
      end
    end
  end

  // Next-state logic; initLoad aborts whatever is in flight.
  always_comb begin
    state_next_s = state_r;
    if (initLoad) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_next_s = accept_s ? ST_READ : ST_IDLE;
        ST_READ:  state_next_s = ST_CHECK;
        ST_CHECK: state_next_s = (err_s != ERR_NONE) ? ST_ERR : ST_WRITE;
        ST_WRITE: state_next_s = ST_DONE;
        ST_DONE:  state_next_s = ST_IDLE;
        ST_ERR:   state_next_s = ST_IDLE;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Board, latched move operands and registered result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_r       <= INIT_BOARD;
      from_r        <= 6'd0;
      to_r          <= 6'd0;
      src_r         <= 4'h0;
      dst_r         <= 4'h0;
      moveDone      <= 1'b0;
      moveErr       <= 1'b0;
      errCode       <= 2'b00;
      capturedPiece <= 4'h0;
`ifdef BOARD_WRITER_PROMOTION_EN
      promoted      <= 1'b0;
`endif
    end else if (initLoad) begin
      board_r  <= INIT_BOARD;
      moveDone <= 1'b0;
      moveErr  <= 1'b0;
`ifdef BOARD_WRITER_PROMOTION_EN
      promoted <= 1'b0;
`endif
    end else begin
      moveDone <= 1'b0;
      moveErr  <= 1'b0;
`ifdef BOARD_WRITER_PROMOTION_EN
      promoted <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            from_r <= fromPos;
            to_r   <= toPos;
          end
        end
        ST_READ: begin
          src_r <= src_s;
          dst_r <= dst_s;
        end
        ST_CHECK: begin
          // Pulse is raised on entry to ERR so it lines up with that state.
          if (err_s != ERR_NONE) begin
            moveErr <= 1'b1;
            errCode <= err_s;
          end
        end
        ST_WRITE: begin
          board_r       <= write_board_s;
          moveDone      <= 1'b1;
          capturedPiece <= dst_r;
`ifdef BOARD_WRITER_PROMOTION_EN
          promoted      <= promote_s;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_writer.sv
// tb_board_writer: directed self-checking bench for board_writer.
// Covers reset, plain move timing, capture, error priority, back-to-back
// handshake, initLoad abort and priority, asynchronous mid-move reset and
// pawn promotion (expected value depends on BOARD_WRITER_PROMOTION_EN).
module tb_board_writer;

  // Square 9 = 1, 20 = 4, 28 = C, 30 = 2, 31 = 3, 50 = 1; all others empty.
  localparam logic [255:0] INIT = (256'h1 << 36) | (256'h4 << 80) | (256'hC << 112) |
                                  (256'h2 << 120) | (256'h3 << 124) | (256'h1 << 200);

  logic         clk;
  logic         rst_n;
  logic         initLoad;
  logic         moveValid;
  logic         moveReady;
  logic [5:0]   fromPos;
  logic [5:0]   toPos;
  logic [255:0] bigBoard;
  logic         moveDone;
  logic         moveErr;
  logic [1:0]   errCode;
  logic [3:0]   capturedPiece;
  logic         busy;
`ifdef BOARD_WRITER_PROMOTION_EN
  logic         promoted;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [255:0] exp_board;

  board_writer #(.INIT_BOARD(INIT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .initLoad      (initLoad),
    .moveValid     (moveValid),
    .moveReady     (moveReady),
    .fromPos       (fromPos),
    .toPos         (toPos),
    .bigBoard      (bigBoard),
    .moveDone      (moveDone),
    .moveErr       (moveErr),
    .errCode       (errCode),
    .capturedPiece (capturedPiece),
    .busy          (busy)
`ifdef BOARD_WRITER_PROMOTION_EN
    ,
    .promoted      (promoted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sq(input logic [255:0] b, input int n);
    return b[n * 4 +: 4];
  endfunction

  function automatic logic [255:0] set_sq(input logic [255:0] b, input int n, input logic [3:0] v);
    logic [255:0] r;
    r = b;
    r[n * 4 +: 4] = v;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a move at a falling edge and returns 1 time unit after the accept edge E0.
  task automatic start_move(input logic [5:0] f, input logic [5:0] t);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!moveReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", 256'(moveReady), 256'd1);
    fromPos   = f;
    toPos     = t;
    moveValid = 1'b1;
    @(posedge clk);
    #1;
    moveValid = 1'b0;
    fromPos   = 6'd63;
    toPos     = 6'd62;
  endtask

  task automatic err_move(input logic [5:0] f, input logic [5:0] t, input logic [1:0] code,
                          input string tag);
    start_move(f, t);
    tick(2);
    check({tag, "_err"},   256'(moveErr),  256'd1);
    check({tag, "_code"},  256'(errCode),  256'(code));
    check({tag, "_done"},  256'(moveDone), 256'd0);
    check({tag, "_board"}, bigBoard,       exp_board);
    tick(1);
    check({tag, "_err_end"}, 256'(moveErr),   256'd0);
    check({tag, "_ready"},   256'(moveReady), 256'd1);
    check({tag, "_board2"},  bigBoard,        exp_board);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    initLoad  = 1'b0;
    moveValid = 1'b0;
    fromPos   = 6'd0;
    toPos     = 6'd0;
    exp_board = INIT;
    #1 rst_n = 1'b0;
    #10;
    check("rst_board",    bigBoard,             INIT);
    check("rst_ready",    256'(moveReady),      256'd1);
    check("rst_done",     256'(moveDone),       256'd0);
    check("rst_err",      256'(moveErr),        256'd0);
    check("rst_code",     256'(errCode),        256'd0);
    check("rst_captured", 256'(capturedPiece),  256'd0);
    check("rst_busy",     256'(busy),           256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain move 9 -> 10, timing relative to accept edge E0.
    start_move(6'd9, 6'd10);
    check("mv_busy", 256'(busy), 256'd1);
    tick(2);
    check("mv_pre_sq10", 256'(sq(bigBoard, 10)), 256'd0);
    check("mv_pre_done", 256'(moveDone), 256'd0);
    tick(1);
    exp_board = set_sq(set_sq(exp_board, 10, 4'h1), 9, 4'h0);
    check("mv_board",    bigBoard,             exp_board);
    check("mv_done",     256'(moveDone),       256'd1);
    check("mv_captured", 256'(capturedPiece),  256'd0);
    check("mv_ready_lo", 256'(moveReady),      256'd0);
    tick(1);
    check("mv_done_end", 256'(moveDone),  256'd0);
    check("mv_ready_hi", 256'(moveReady), 256'd1);

    // Capture of a black piece by a white one.
    start_move(6'd20, 6'd28);
    tick(3);
    exp_board = set_sq(set_sq(exp_board, 28, 4'h4), 20, 4'h0);
    check("cap_board",    bigBoard,            exp_board);
    check("cap_done",     256'(moveDone),      256'd1);
    check("cap_captured", 256'(capturedPiece), 256'hC);
    tick(1);

    // Error priority; square 5 is empty so same-square must outrank empty source.
    err_move(6'd5,  6'd5,  2'b11, "err_same_sq");
    err_move(6'd40, 6'd41, 2'b01, "err_empty");
    err_move(6'd40, 6'd31, 2'b01, "err_empty_onto_white");
    err_move(6'd30, 6'd31, 2'b10, "err_same_colour");
    check("err_captured_held", 256'(capturedPiece), 256'hC);

    // Back-to-back with moveValid held high.
    @(negedge clk);
    fromPos   = 6'd31;
    toPos     = 6'd40;
    moveValid = 1'b1;
    @(posedge clk);
    #1;
    fromPos = 6'd10;
    toPos   = 6'd9;
    check("b2b_ready_e0", 256'(moveReady), 256'd0);
    tick(1);
    check("b2b_ready_e1", 256'(moveReady), 256'd0);
    tick(1);
    check("b2b_ready_e2", 256'(moveReady), 256'd0);
    tick(1);
    exp_board = set_sq(set_sq(exp_board, 40, 4'h3), 31, 4'h0);
    check("b2b_ready_e3", 256'(moveReady),     256'd0);
    check("b2b_done1",    256'(moveDone),      256'd1);
    check("b2b_board1",   bigBoard,            exp_board);
    check("b2b_cap1",     256'(capturedPiece), 256'd0);
    tick(1);
    check("b2b_ready_e4", 256'(moveReady), 256'd1);
    check("b2b_idle_e4",  256'(busy),      256'd0);
    tick(1);
    check("b2b_accept_e5", 256'(busy), 256'd1);
    moveValid = 1'b0;
    tick(3);
    exp_board = set_sq(set_sq(exp_board, 9, 4'h1), 10, 4'h0);
    check("b2b_done2",  256'(moveDone), 256'd1);
    check("b2b_board2", bigBoard,       exp_board);
    tick(1);

    // initLoad while move 9 -> 10 sits in CHECK.
    start_move(6'd9, 6'd10);
    tick(1);
    initLoad = 1'b1;
    tick(1);
    initLoad  = 1'b0;
    exp_board = INIT;
    check("il_board", bigBoard,       INIT);
    check("il_busy",  256'(busy),     256'd0);
    check("il_done",  256'(moveDone), 256'd0);
    check("il_err",   256'(moveErr),  256'd0);
    tick(2);
    check("il_done_late", 256'(moveDone), 256'd0);
    check("il_err_late",  256'(moveErr),  256'd0);
    check("il_board_late", bigBoard, INIT);

    // initLoad outranks a simultaneous move request.
    @(negedge clk);
    initLoad  = 1'b1;
    moveValid = 1'b1;
    fromPos   = 6'd9;
    toPos     = 6'd10;
    #1;
    check("ilp_ready", 256'(moveReady), 256'd0);
    @(posedge clk);
    #1;
    initLoad  = 1'b0;
    moveValid = 1'b0;
    check("ilp_busy", 256'(busy), 256'd0);
    tick(4);
    check("ilp_board", bigBoard, INIT);

    // Asynchronous reset during WRITE of a second move.
    start_move(6'd20, 6'd28);
    tick(3);
    check("rr_cap", 256'(capturedPiece), 256'hC);
    tick(1);
    start_move(6'd28, 6'd20);
    tick(2);
    check("rr_busy_pre", 256'(busy), 256'd1);
    rst_n = 1'b0;
    #1;
    check("rr_board",    bigBoard,            INIT);
    check("rr_done",     256'(moveDone),      256'd0);
    check("rr_err",      256'(moveErr),       256'd0);
    check("rr_busy",     256'(busy),          256'd0);
    check("rr_captured", 256'(capturedPiece), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pawn from square 50 onto square 15 (row 7).
    start_move(6'd50, 6'd15);
    tick(3);
    check("promo_src", 256'(sq(bigBoard, 50)), 256'd0);
    check("promo_done", 256'(moveDone), 256'd1);
`ifdef BOARD_WRITER_PROMOTION_EN
    check("promo_sq15", 256'(sq(bigBoard, 15)), 256'h5);
    check("promo_flag", 256'(promoted), 256'd1);
    tick(1);
    check("promo_flag_end", 256'(promoted), 256'd0);
`else
    check("promo_sq15", 256'(sq(bigBoard, 15)), 256'h1);
    tick(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
